// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues single-cycle-latency RAM reads and
// queues returned instructions with their PC for decode over a valid/ready handshake.
module fetch_queue #(
   parameter int unsigned AW    = 8,
   parameter int unsigned IW    = 16,
   parameter int unsigned STEP  = 2,
   parameter int unsigned DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [IW-1:0] mem_data,
   output logic          ins_valid,
   input  logic          ins_ready,
   output logic [IW-1:0] ins_data,
   output logic [AW-1:0] ins_pc,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   input  logic          halt,
   output logic          halted,
   output logic [AW-1:0] pc
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e            r_state, w_state_nxt;
   logic [AW-1:0]     r_pc;
   logic [AW-1:0]     r_rsp_pc;
   logic              r_inflight;
   logic              r_halted;
   logic [PtrW-1:0]   r_wptr, r_rptr;
   logic [CntW-1:0]   r_count;
   logic [IW-1:0]     r_mem_data [DEPTH];
   logic [AW-1:0]     r_mem_pc   [DEPTH];

   logic              w_push, w_pop, w_issue;
   logic [CntW-1:0]   w_used;

   always_comb begin
      w_state_nxt = r_state;
      if (redirect) begin
         w_state_nxt = StRun;
      end else if (r_state == StRun && halt) begin
         w_state_nxt = StHalt;
      end
   end

   assign ins_valid = (r_count != '0);
   assign w_pop     = ins_valid && ins_ready;
   // A redirect discards the response returning in the same cycle.
   assign w_push    = r_inflight && !redirect;
   // Slots claimed by queued and in-flight words, crediting back a same-cycle pop.
   assign w_used    = r_count + CntW'(r_inflight) - CntW'(w_pop);
   assign w_issue   = !reset && (r_state == StRun) && !redirect && (w_used < CntW'(DEPTH));

   assign mem_rd    = w_issue;
   assign mem_addr  = r_pc;
   assign pc        = r_pc;
   assign halted    = r_halted;
   assign ins_data  = r_mem_data[r_rptr];
   assign ins_pc    = r_mem_pc[r_rptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StRun;
         r_pc       <= '0;
         r_rsp_pc   <= '0;
         r_inflight <= 1'b0;
         r_halted   <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_issue;
         r_halted   <= (w_state_nxt == StHalt) && !w_issue;
         if (redirect) begin
            r_pc <= redirect_pc;
         end else if (w_issue) begin
            r_pc <= r_pc + AW'(STEP);
         end
         if (w_issue) begin
            r_rsp_pc <= r_pc;
         end
         if (redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
               r_rptr <= r_rptr + PtrW'(1);
            end
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_mem_data[r_wptr] <= mem_data;
         r_mem_pc[r_wptr]   <= r_rsp_pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic checked
// against an in-order program-stream scoreboard and halt/credit rules.
module tb_fetch_queue;

   localparam int unsigned AW    = 8;
   localparam int unsigned IW    = 16;
   localparam int unsigned STEP  = 2;
   localparam int unsigned DEPTH = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [IW-1:0] mem_data;
   logic          ins_valid;
   logic          ins_ready;
   logic [IW-1:0] ins_data;
   logic [AW-1:0] ins_pc;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          halt;
   logic          halted;
   logic [AW-1:0] pc;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_queue #(.AW(AW), .IW(IW), .STEP(STEP), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .ins_valid   (ins_valid),
      .ins_ready   (ins_ready),
      .ins_data    (ins_data),
      .ins_pc      (ins_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .halted      (halted),
      .pc          (pc)
   );

   function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
      case (a)
         8'h00:   return 16'h5B01;
         8'h02:   return 16'h5A02;
         8'h04:   return 16'h9214;
         8'h06:   return 16'hE002;
         default: return {a ^ 8'hA5, a};
      endcase
   endfunction

   // Single-cycle-latency RAM; garbage on the bus when no read was issued.
   always @(posedge clk) begin
      mem_data <= mem_rd ? rom(mem_addr) : IW'($urandom);
   end

   // Reference model: expected next PC of the program stream, run/halt state, credit counts.
   logic [AW-1:0] exp_next;
   bit            m_halt;
   int            m_hage;
   int            issued, popped, n_pops;
   bit            p_hold;
   logic [AW-1:0] p_pc;
   logic [IW-1:0] p_data;
   // Values sampled in the cycle just completed.
   logic          s_valid, s_rd, s_halted, s_pop;
   logic [AW-1:0] s_pc, s_addr, s_pcout;
   logic [IW-1:0] s_data;

   task automatic cyc();
      #1;
      s_valid  = ins_valid;
      s_pc     = ins_pc;
      s_data   = ins_data;
      s_rd     = mem_rd;
      s_addr   = mem_addr;
      s_halted = halted;
      s_pcout  = pc;
      s_pop    = (ins_valid === 1'b1) && ins_ready && !redirect && !reset;
      if (reset) begin
         checks++;
         if (mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL rd_in_reset: mem_rd=%b required 0", mem_rd);
         end
      end else begin
         if (redirect) begin
            checks++;
            if (mem_rd !== 1'b0) begin
               failures++;
               $display("FAIL rd_in_redirect: mem_rd=%b required 0", mem_rd);
            end
         end
         if (m_halt) begin
            checks++;
            if (mem_rd !== 1'b0) begin
               failures++;
               $display("FAIL rd_while_halted: mem_rd=%b required 0", mem_rd);
            end
         end
         if (!m_halt) begin
            checks++;
            if (halted !== 1'b0) begin
               failures++;
               $display("FAIL halted_in_run: halted=%b required 0", halted);
            end
         end else if (m_hage >= 1) begin
            checks++;
            if (halted !== 1'b1) begin
               failures++;
               $display("FAIL halted_settled: halted=%b required 1", halted);
            end
         end
         if (p_hold) begin
            checks++;
            if (ins_valid !== 1'b1 || ins_pc !== p_pc || ins_data !== p_data) begin
               failures++;
               $display("FAIL head_stable: valid=%b pc=%h data=%h required 1 %h %h",
                        ins_valid, ins_pc, ins_data, p_pc, p_data);
            end
         end
         if (s_pop) begin
            checks++;
            if (ins_pc !== exp_next || ins_data !== rom(exp_next)) begin
               failures++;
               $display("FAIL stream: pc=%h data=%h required %h %h",
                        ins_pc, ins_data, exp_next, rom(exp_next));
            end
            exp_next = exp_next + AW'(STEP);
            popped++;
            n_pops++;
         end
         if (mem_rd === 1'b1) begin
            issued++;
            checks++;
            if (issued - popped > int'(DEPTH)) begin
               failures++;
               $display("FAIL credit: outstanding=%0d required <=%0d", issued - popped, DEPTH);
            end
         end
      end
      p_hold = (ins_valid === 1'b1) && (ins_ready === 1'b0) && !redirect && !reset;
      p_pc   = ins_pc;
      p_data = ins_data;
      @(posedge clk);
      if (reset) begin
         exp_next = '0;
         m_halt   = 1'b0;
         m_hage   = 0;
         issued   = 0;
         popped   = 0;
      end else if (redirect) begin
         exp_next = redirect_pc;
         m_halt   = 1'b0;
         m_hage   = 0;
         issued   = 0;
         popped   = 0;
      end else if (m_halt) begin
         m_hage++;
      end else if (halt) begin
         m_halt = 1'b1;
         m_hage = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      halt     = 1'b0;
      redirect = 1'b0;
      cyc();
      cyc();
      reset    = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      ins_ready = 1'b0;
      cyc();
      cyc();
      checks++;
      if (s_valid !== 1'b0 || s_pcout !== '0 || s_halted !== 1'b0 || s_rd !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: valid=%b pc=%h halted=%b rd=%b required 0 00 0 0",
                  s_valid, s_pcout, s_halted, s_rd);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic_stream();
      logic [IW-1:0] words [4];
      int first;
      words = '{16'h5B01, 16'h5A02, 16'h9214, 16'hE002};
      first = -1;
      do_reset();
      ins_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (s_valid === 1'b1 && first < 0) first = i;
         if (i >= 2 && i <= 5) begin
            checks++;
            if (s_pop !== 1'b1 || s_pc !== AW'(2 * (i - 2)) || s_data !== words[i-2]) begin
               failures++;
               $display("FAIL basic_seq: cycle %0d pop=%b pc=%h data=%h required 1 %h %h",
                        i, s_pop, s_pc, s_data, AW'(2 * (i - 2)), words[i-2]);
            end
         end
      end
      checks++;
      if (first != 2) begin
         failures++;
         $display("FAIL basic_latency: first valid cycle %0d required 2", first);
      end
   endtask

   task automatic test_back_pressure();
      int nrd, p0;
      nrd = 0;
      do_reset();
      ins_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (s_rd === 1'b1) nrd++;
      end
      checks++;
      if (nrd != int'(DEPTH)) begin
         failures++;
         $display("FAIL bp_issues: reads=%0d required %0d", nrd, DEPTH);
      end
      checks++;
      if (s_valid !== 1'b1 || s_pc !== 8'h00) begin
         failures++;
         $display("FAIL bp_head: valid=%b pc=%h required 1 00", s_valid, s_pc);
      end
      ins_ready = 1'b1;
      p0 = n_pops;
      for (int i = 0; i < 8; i++) cyc();
      checks++;
      if (n_pops - p0 != 8) begin
         failures++;
         $display("FAIL bp_release: pops=%0d required 8", n_pops - p0);
      end
   endtask

   task automatic test_redirect();
      int first;
      first = -1;
      do_reset();
      ins_ready = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      ins_ready   = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 8'h40;
      cyc();
      redirect  = 1'b0;
      ins_ready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         cyc();
         if (j == 0) begin
            checks++;
            if (s_rd !== 1'b1 || s_addr !== 8'h40) begin
               failures++;
               $display("FAIL redir_fetch: rd=%b addr=%h required 1 40", s_rd, s_addr);
            end
         end
         if (s_valid === 1'b1 && first < 0) begin
            first = j;
            checks++;
            if (s_pc !== 8'h40) begin
               failures++;
               $display("FAIL redir_first_pc: pc=%h required 40", s_pc);
            end
         end
      end
      checks++;
      if (first != 2) begin
         failures++;
         $display("FAIL redir_latency: first valid %0d required 2", first);
      end
   endtask

   task automatic test_halt_resume();
      int p0;
      do_reset();
      p0 = n_pops;
      ins_ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      halt = 1'b1;
      cyc();
      halt = 1'b0;
      cyc();
      checks++;
      if (s_rd !== 1'b0) begin
         failures++;
         $display("FAIL halt_rd: rd=%b required 0", s_rd);
      end
      cyc();
      checks++;
      if (s_halted !== 1'b1) begin
         failures++;
         $display("FAIL halt_flag: halted=%b required 1", s_halted);
      end
      for (int i = 0; i < 4; i++) cyc();
      checks++;
      if (n_pops - p0 != 5 || s_valid !== 1'b0) begin
         failures++;
         $display("FAIL halt_drain: pops=%0d valid=%b required 5 0", n_pops - p0, s_valid);
      end
      redirect    = 1'b1;
      redirect_pc = 8'h10;
      cyc();
      redirect = 1'b0;
      cyc();
      checks++;
      if (s_rd !== 1'b1 || s_addr !== 8'h10 || s_halted !== 1'b0) begin
         failures++;
         $display("FAIL resume: rd=%b addr=%h halted=%b required 1 10 0", s_rd, s_addr, s_halted);
      end
      cyc();
      cyc();
      checks++;
      if (s_valid !== 1'b1 || s_pc !== 8'h10) begin
         failures++;
         $display("FAIL resume_pc: valid=%b pc=%h required 1 10", s_valid, s_pc);
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] got [$];
      logic [AW-1:0] want [3];
      want = '{8'hFC, 8'hFE, 8'h00};
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 8'hFC;
      cyc();
      redirect  = 1'b0;
      ins_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cyc();
         if (s_pop) got.push_back(s_pc);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got.size() <= k || got[k] !== want[k]) begin
            failures++;
            $display("FAIL wrap_seq: entry %0d got %h required %h", k,
                     (got.size() > k) ? got[k] : 8'hxx, want[k]);
         end
      end
   endtask

   task automatic test_halt_redirect();
      do_reset();
      ins_ready = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      halt        = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 8'h80;
      cyc();
      halt     = 1'b0;
      redirect = 1'b0;
      cyc();
      checks++;
      if (s_rd !== 1'b1 || s_addr !== 8'h80 || s_halted !== 1'b0) begin
         failures++;
         $display("FAIL halt_redir: rd=%b addr=%h halted=%b required 1 80 0",
                  s_rd, s_addr, s_halted);
      end
      for (int i = 0; i < 4; i++) cyc();
   endtask

   task automatic test_reset_mid();
      do_reset();
      ins_ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      checks++;
      if (s_valid !== 1'b0 || s_pcout !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid: valid=%b pc=%h required 0 00", s_valid, s_pcout);
      end
      for (int i = 0; i < 6; i++) cyc();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         ins_ready   = ($urandom_range(0, 9) < 7);
         halt        = ($urandom_range(0, 99) < 4);
         redirect    = ($urandom_range(0, 99) < 3);
         redirect_pc = AW'($urandom);
         reset       = ($urandom_range(0, 199) == 0);
         cyc();
      end
      reset    = 1'b0;
      halt     = 1'b0;
      redirect = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      ins_ready   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      halt        = 1'b0;
      m_halt      = 1'b0;
      m_hage      = 0;
      issued      = 0;
      popped      = 0;
      n_pops      = 0;
      p_hold      = 1'b0;
      exp_next    = '0;
      @(negedge clk);
      test_reset();
      test_basic_stream();
      test_back_pressure();
      test_redirect();
      test_halt_resume();
      test_wrap();
      test_halt_redirect();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
